// File: rtl/register_bank_fwd.sv
// ----------------------------------------------------------------------------
// register_bank_fwd: register file with internal EX/DM/WB forwarding, load-use stall
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module register_bank_fwd #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] RA,
  input  logic [ADDR_W-1:0] RB,
  input  logic [DATA_W-1:0] imm,
  input  logic              imm_sel,
  input  logic              issue,
  input  logic [ADDR_W-1:0] RW_id,
  input  logic              wen_id,
  input  logic              load_id,
  input  logic [DATA_W-1:0] ans_ex,
  input  logic [DATA_W-1:0] ans_dm,
  input  logic [DATA_W-1:0] ans_wb,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic [1:0]        fwd_sel_A,
  output logic [1:0]        fwd_sel_B,
  output logic              stall
);

  localparam int DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];

  logic              ex_v, dm_v, wb_v;
  logic              ex_ld;
  logic [ADDR_W-1:0] ex_rd, dm_rd, wb_rd;
  logic              ex_v_nxt;

  genvar p;
  for (p = 0; p < 2; p++) begin : g_port
    logic [ADDR_W-1:0] addr;
    logic              is_zero;
    logic              hit_ex, hit_dm, hit_wb;
    logic [1:0]        sel;
    logic [DATA_W-1:0] val;
    logic              haz;

    assign addr    = (p == 0) ? RA : RB;
    assign is_zero = (ZERO_REG != 0) && (addr == '0);
    assign hit_ex  = ex_v && (ex_rd == addr) && !is_zero;
    assign hit_dm  = dm_v && (dm_rd == addr) && !is_zero;
    assign hit_wb  = wb_v && (wb_rd == addr) && !is_zero;
    // A load still in EX has no data yet: report the EX source but flag a hazard.
    assign haz     = hit_ex && ex_ld;

    always_comb begin
      sel = 2'b00;
      val = is_zero ? '0 : regs[addr];
      if (hit_ex) begin
        sel = 2'b01;
        val = ans_ex;
      end else if (hit_dm) begin
        sel = 2'b10;
        val = ans_dm;
      end else if (hit_wb) begin
        sel = 2'b11;
        val = ans_wb;
      end
    end
  end

  assign stall     = !rst && issue && (g_port[0].haz || (g_port[1].haz && !imm_sel));
  assign A         = rst ? '0 : g_port[0].val;
  assign B         = imm_sel ? imm : (rst ? '0 : g_port[1].val);
  assign fwd_sel_A = rst ? 2'b00 : g_port[0].sel;
  assign fwd_sel_B = (rst || imm_sel) ? 2'b00 : g_port[1].sel;

  // Writes to the hard-wired zero register never enter the tag pipeline.
  assign ex_v_nxt = issue && !stall && wen_id && !((ZERO_REG != 0) && (RW_id == '0));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ex_v  <= 1'b0;
      dm_v  <= 1'b0;
      wb_v  <= 1'b0;
      ex_ld <= 1'b0;
      ex_rd <= '0;
      dm_rd <= '0;
      wb_rd <= '0;
    end else begin
      ex_v  <= ex_v_nxt;
      ex_rd <= RW_id;
      ex_ld <= load_id && ex_v_nxt;
      dm_v  <= ex_v;
      dm_rd <= ex_rd;
      wb_v  <= dm_v;
      wb_rd <= dm_rd;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_v) begin
      regs[wb_rd] <= ans_wb;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_register_bank_fwd.sv
// ----------------------------------------------------------------------------
// tb_register_bank_fwd: randomized + directed self-checking bench for register_bank_fwd
// Revision: 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_register_bank_fwd;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  RA, RB, RW_id;
  logic [15:0] imm, ans_ex, ans_dm, ans_wb;
  logic        imm_sel, issue, wen_id, load_id;
  logic [15:0] A, B;
  logic [1:0]  fwd_sel_A, fwd_sel_B;
  logic        stall;

  logic [2:0]  d_RA, d_RB, d_RW;
  logic [31:0] d_imm, d_ans_ex, d_ans_dm, d_ans_wb, d_A, d_B;
  logic        d_imm_sel, d_issue, d_wen, d_load, d_stall;
  logic [1:0]  d_sa, d_sb;

  int vectors = 0;
  int miss    = 0;

  always #5 clk = ~clk;

  register_bank_fwd dut (
    .clk(clk), .rst(rst), .RA(RA), .RB(RB), .imm(imm), .imm_sel(imm_sel),
    .issue(issue), .RW_id(RW_id), .wen_id(wen_id), .load_id(load_id),
    .ans_ex(ans_ex), .ans_dm(ans_dm), .ans_wb(ans_wb),
    .A(A), .B(B), .fwd_sel_A(fwd_sel_A), .fwd_sel_B(fwd_sel_B), .stall(stall)
  );

  register_bank_fwd #(.DATA_W(32), .ADDR_W(3), .ZERO_REG(1)) dut32 (
    .clk(clk), .rst(rst), .RA(d_RA), .RB(d_RB), .imm(d_imm), .imm_sel(d_imm_sel),
    .issue(d_issue), .RW_id(d_RW), .wen_id(d_wen), .load_id(d_load),
    .ans_ex(d_ans_ex), .ans_dm(d_ans_dm), .ans_wb(d_ans_wb),
    .A(d_A), .B(d_B), .fwd_sel_A(d_sa), .fwd_sel_B(d_sb), .stall(d_stall)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: history of the last three issued writers, index 0 = most recent.
  bit          m_v  [3];
  logic [4:0]  m_rd [3];
  bit          m_ld [3];
  logic [15:0] m_reg [32];

  function automatic void lookup(input logic [4:0] r, output logic [1:0] sel,
                                 output logic [15:0] val, output logic haz);
    sel = 2'b00;
    val = m_reg[r];
    haz = 1'b0;
    if (r != 5'd0) begin
      for (int k = 2; k >= 0; k--) begin
        if (m_v[k] && m_rd[k] == r) begin
          sel = 2'(k + 1);
          val = (k == 0) ? ans_ex : (k == 1) ? ans_dm : ans_wb;
          haz = (k == 0) && m_ld[0];
        end
      end
    end else begin
      val = 16'h0;
    end
  endfunction

  always @(posedge clk or posedge rst) begin
    logic [1:0]  s0, s1;
    logic [15:0] v0, v1;
    logic        h0, h1, st;
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        m_v[i] = 1'b0; m_rd[i] = 5'd0; m_ld[i] = 1'b0;
      end
      for (int i = 0; i < 32; i++) m_reg[i] = 16'h0;
    end else begin
      lookup(RA, s0, v0, h0);
      lookup(RB, s1, v1, h1);
      st = issue && (h0 || (h1 && !imm_sel));
      if (m_v[2]) m_reg[m_rd[2]] = ans_wb;
      for (int k = 2; k > 0; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_ld[k] = m_ld[k-1];
      end
      m_v[0]  = issue && !st && wen_id && (RW_id != 5'd0);
      m_rd[0] = RW_id;
      m_ld[0] = load_id;
    end
  end

  always @(negedge clk) begin
    logic [1:0]  sa, sb;
    logic [15:0] va, vb;
    logic        ha, hb, es;
    if (rst) begin
      sa = 2'b00; sb = 2'b00; va = 16'h0; vb = imm_sel ? imm : 16'h0; es = 1'b0;
    end else begin
      lookup(RA, sa, va, ha);
      lookup(RB, sb, vb, hb);
      es = issue && (ha || (hb && !imm_sel));
      if (imm_sel) begin
        sb = 2'b00;
        vb = imm;
      end
    end
    chk("stall", 32'(stall), 32'(es));
    chk("fwd_sel_A", 32'(fwd_sel_A), 32'(sa));
    chk("fwd_sel_B", 32'(fwd_sel_B), 32'(sb));
    if (!es) begin
      chk("A", 32'(A), 32'(va));
      chk("B", 32'(B), 32'(vb));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    issue = 1'b0; wen_id = 1'b0; load_id = 1'b0; imm_sel = 1'b0;
    RA = 5'd0; RB = 5'd0; RW_id = 5'd0; imm = 16'h0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ans_ex = 16'h0; ans_dm = 16'h0; ans_wb = 16'h0;
    d_RA = 3'd0; d_RB = 3'd0; d_RW = 3'd0; d_imm = 32'h0; d_imm_sel = 1'b0;
    d_issue = 1'b0; d_wen = 1'b0; d_load = 1'b0;
    d_ans_ex = 32'h0; d_ans_dm = 32'h0; d_ans_wb = 32'hDEADBEEF;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0; RA = 5'd5; RB = 5'd6;
    #2;
    chk("lit_rst_A", 32'(A), 32'h0);
    chk("lit_rst_B", 32'(B), 32'h0);
    chk("lit_rst_selA", 32'(fwd_sel_A), 32'h0);
    chk("lit_rst_stall", 32'(stall), 32'h0);

    // Producer to r7 walks EX -> DM -> WB -> file
    cyc(); idle(); issue = 1'b1; wen_id = 1'b1; RW_id = 5'd7;
    cyc(); idle(); RB = 5'd7; ans_ex = 16'hC000;
    #2; chk("lit_ex_B", 32'(B), 32'hC000); chk("lit_ex_sel", 32'(fwd_sel_B), 32'h1);
    cyc(); ans_dm = 16'hD000;
    #2; chk("lit_dm_B", 32'(B), 32'hD000); chk("lit_dm_sel", 32'(fwd_sel_B), 32'h2);
    cyc(); ans_wb = 16'hE000;
    #2; chk("lit_wb_B", 32'(B), 32'hE000); chk("lit_wb_sel", 32'(fwd_sel_B), 32'h3);
    cyc(); ans_ex = 16'h0; ans_dm = 16'h0; ans_wb = 16'h0;
    #2; chk("lit_rf_B", 32'(B), 32'hE000); chk("lit_rf_sel", 32'(fwd_sel_B), 32'h0);

    // Back-to-back writers to r7: youngest wins
    cyc(); idle(); issue = 1'b1; wen_id = 1'b1; RW_id = 5'd7;
    cyc(); ans_ex = 16'h1111;
    cyc(); idle(); RB = 5'd7; ans_ex = 16'h2222; ans_dm = 16'h1111;
    #2; chk("lit_b2b_B", 32'(B), 32'h2222); chk("lit_b2b_sel", 32'(fwd_sel_B), 32'h1);

    // Load-use hazard
    cyc(); idle(); issue = 1'b1; wen_id = 1'b1; load_id = 1'b1; RW_id = 5'd3;
    cyc(); idle(); issue = 1'b1; RA = 5'd3;
    #2; chk("lit_lu_stall", 32'(stall), 32'h1); chk("lit_lu_sel", 32'(fwd_sel_A), 32'h1);
    cyc(); ans_dm = 16'hABCD;
    #2; chk("lit_lu_A", 32'(A), 32'hABCD); chk("lit_lu_selA", 32'(fwd_sel_A), 32'h2);
    chk("lit_lu_stall2", 32'(stall), 32'h0);
    cyc(); idle(); issue = 1'b1; wen_id = 1'b1; load_id = 1'b1; RW_id = 5'd3;
    cyc(); idle(); issue = 1'b1; RB = 5'd3; imm_sel = 1'b1; imm = 16'hFFFF;
    #2; chk("lit_imm_stall", 32'(stall), 32'h0); chk("lit_imm_B", 32'(B), 32'hFFFF);
    chk("lit_imm_sel", 32'(fwd_sel_B), 32'h0);

    // Register zero never forwards or stalls
    cyc(); idle(); issue = 1'b1; wen_id = 1'b1; load_id = 1'b1; RW_id = 5'd0;
    ans_ex = 16'h5555;
    for (int i = 0; i < 4; i++) begin
      cyc(); idle(); issue = 1'b1; RA = 5'd0;
      ans_ex = 16'h5555; ans_dm = 16'h5555; ans_wb = 16'h5555;
      #2; chk("lit_r0_A", 32'(A), 32'h0); chk("lit_r0_sel", 32'(fwd_sel_A), 32'h0);
      chk("lit_r0_stall", 32'(stall), 32'h0);
    end

    // Asynchronous reset in the middle of a forward
    cyc(); idle(); issue = 1'b1; wen_id = 1'b1; RW_id = 5'd7;
    cyc(); idle(); RA = 5'd7; ans_ex = 16'h1234;
    #2; chk("lit_pre_A", 32'(A), 32'h1234);
    rst = 1'b1;
    #1; chk("lit_mid_A", 32'(A), 32'h0); chk("lit_mid_sel", 32'(fwd_sel_A), 32'h0);
    chk("lit_mid_stall", 32'(stall), 32'h0);
    cyc(); rst = 1'b0;
    #2; chk("lit_post_A", 32'(A), 32'h0); chk("lit_post_sel", 32'(fwd_sel_A), 32'h0);

    // Wide/narrow build: r7 visible from the file three clocks after issue
    cyc(); d_issue = 1'b1; d_wen = 1'b1; d_RW = 3'd7;
    cyc(); d_issue = 1'b0; d_wen = 1'b0; d_RA = 3'd7;
    repeat (3) cyc();
    #2; chk("lit_w32_A", d_A, 32'hDEADBEEF); chk("lit_w32_sel", 32'(d_sa), 32'h0);
    chk("lit_w32_B", d_B, 32'h0); chk("lit_w32_selB", 32'(d_sb), 32'h0);
    chk("lit_w32_stall", 32'(d_stall), 32'h0);

    for (int n = 0; n < 600; n++) begin
      cyc();
      rst     = ($urandom_range(0, 99) < 2);
      issue   = ($urandom_range(0, 9) < 8);
      wen_id  = ($urandom_range(0, 9) < 7);
      load_id = ($urandom_range(0, 9) < 3);
      imm_sel = ($urandom_range(0, 9) < 2);
      RA      = 5'($urandom_range(0, 7));
      RB      = 5'($urandom_range(0, 7));
      RW_id   = 5'($urandom_range(0, 7));
      imm     = 16'($urandom);
      ans_ex  = 16'($urandom);
      ans_dm  = 16'($urandom);
      ans_wb  = 16'($urandom);
    end
    cyc(); rst = 1'b0; idle();
    cyc(); #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miss);
    $finish;
  end

endmodule

`default_nettype wire
